// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The fetch entry carries the PC, the fetched word, and a misaligned-fetch marker.
package ifetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'h0000_0004;

  // Clear the byte-offset bits so the result addresses a whole 32-bit word.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small circular buffer of fetch entries between imem capture and decode.
// Flush wins over push/pop in the same cycle. DEPTH must be a power of two >= 2.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; storage cleared on reset so the head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: owns the PC, issues word reads to a 1-cycle imem,
// buffers responses and hands {pc, instr} to decode over valid/ready.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN -- a misaligned redirect
// produces a single trap-marker entry and halts fetch until the next redirect.
// Without it, redirect targets are silently word-aligned.
module ifetch_stage
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_rEn,
  output logic        imem_oEn,
  output logic [31:0] imem_rAddr,
  input  logic [31:0] imem_rData,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_misalign
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
`ifdef IFETCH_MISALIGN_TRAP_EN
  localparam logic MISALIGN_EN = 1'b1;
`else
  localparam logic MISALIGN_EN = 1'b0;
`endif

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          inflight_q, inflight_d;
  logic          halt_s;
  logic          misalign_push_s;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic          halt_q, halt_d;
  logic          misalign_pend_q, misalign_pend_d;
`endif

  logic          issue_s;
  logic          pop_s;
  logic          push_s;
  fetch_entry_t  push_data_s;
  fetch_entry_t  head_s;
  logic [CW-1:0] fifo_count_s;
  logic [CW-1:0] credit_used_s;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign halt_s          = halt_q;
  assign misalign_push_s = misalign_pend_q;
`else
  assign halt_s          = 1'b0;
  assign misalign_push_s = 1'b0;
`endif

  // Issue decision: a read goes out only if its response is guaranteed a FIFO slot.
  // rst_n gates it so imem sees no request while reset is held.
  always_comb begin
    pop_s         = out_valid & out_ready & ~redirect_valid;
    credit_used_s = fifo_count_s + CW'(inflight_q) - CW'(pop_s);
    if (rst_n && !redirect_valid && !halt_s && (credit_used_s < DEPTH_C)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // PC / in-flight / halt next-state; redirect overrides everything else.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
    halt_d          = halt_q;
    misalign_pend_d = 1'b0;
`endif
    if (redirect_valid) begin
      inflight_d = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      pc_d = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        halt_d          = 1'b1;
        misalign_pend_d = 1'b1;
      end else begin
        halt_d          = 1'b0;
        misalign_pend_d = 1'b0;
      end
`else
      pc_d = align_word(redirect_pc);
`endif
    end else if (issue_s) begin
      pc_d          = pc_q + PC_STEP;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end else begin
      inflight_d = 1'b0;
    end
  end

  // Capture path: imem response or trap marker goes into the FIFO unless flushed.
  always_comb begin
    push_s = ~redirect_valid & (inflight_q | misalign_push_s);
    if (misalign_push_s) begin
      push_data_s = '{pc: pc_q, instr: NOP_INSTR, misalign: 1'b1};
    end else begin
      push_data_s = '{pc: inflight_pc_q, instr: imem_rData, misalign: 1'b0};
    end
  end

  // Fetch-control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0000_0000;
`ifdef IFETCH_MISALIGN_TRAP_EN
      halt_q          <= 1'b0;
      misalign_pend_q <= 1'b0;
`endif
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
      halt_q          <= halt_d;
      misalign_pend_q <= misalign_pend_d;
`endif
    end
  end

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_s),
    .push_data_i (push_data_s),
    .pop_i       (pop_s),
    .flush_i     (redirect_valid),
    .head_o      (head_s),
    .count_o     (fifo_count_s)
  );

  assign imem_rEn     = issue_s;
  assign imem_oEn     = issue_s;
  assign imem_rAddr   = align_word(pc_q);
  assign out_valid    = (fifo_count_s != '0);
  assign out_pc       = head_s.pc;
  assign out_instr    = head_s.instr;
  assign out_misalign = head_s.misalign & MISALIGN_EN;

endmodule

// File: tb/tb_ifetch_stage.sv
// Self-checking bench for ifetch_stage: directed scenarios followed by random
// redirect/backpressure traffic, all checked against a PC-stream reference model.
`timescale 1ns/1ps
module tb_ifetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_rEn, imem_oEn;
  logic [31:0] imem_rAddr;
  logic [31:0] imem_rData = 32'h0000_0000;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0000_0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_instr;
  logic        out_misalign;

  ifetch_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_rEn       (imem_rEn),
    .imem_oEn       (imem_oEn),
    .imem_rAddr     (imem_rAddr),
    .imem_rData     (imem_rData),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_misalign   (out_misalign)
  );

  always #5 clk = ~clk;

  // Instruction memory contents are a fixed hash of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Synchronous imem, 1-cycle latency; garbage when not read so stale capture shows up.
  always @(posedge clk) begin
    if (imem_rEn) imem_rData <= mem_word(imem_rAddr);
    else          imem_rData <= 32'hDEAD_BEEF;
  end

  // Reference model: the entries decode should see, each with the cycle it becomes visible.
  typedef struct {
    int          t;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  exp_t        q[$];
  logic [31:0] issue_pc;
  logic        halted;
  int          now;
  int          n_issue;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called mid-cycle: compare DUT outputs with the model, then advance the model past the edge.
  task automatic model_step();
    logic exp_valid, exp_pop, exp_ren;
    int   outstanding;
    exp_valid = 1'b0;
    if (q.size() > 0) exp_valid = (q[0].t <= now);
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_instr", out_instr, q[0].instr);
      chk("out_misalign", {31'b0, out_misalign}, {31'b0, q[0].mis});
    end
    exp_pop     = exp_valid & out_ready;
    outstanding = q.size() - (exp_pop ? 1 : 0);
    exp_ren     = !redirect_valid && !halted && (outstanding < DEPTH);
    chk("imem_rEn", {31'b0, imem_rEn}, {31'b0, exp_ren});
    chk("imem_oEn", {31'b0, imem_oEn}, {31'b0, exp_ren});
    if (exp_ren) chk("imem_rAddr", imem_rAddr, issue_pc);
    if (imem_rEn) n_issue++;
    if (redirect_valid) begin
      q.delete();
`ifdef IFETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        q.push_back('{now + 2, redirect_pc, 32'h0000_0013, 1'b1});
        halted = 1'b1;
      end else begin
        issue_pc = redirect_pc;
        halted   = 1'b0;
      end
`else
      issue_pc = {redirect_pc[31:2], 2'b00};
      halted   = 1'b0;
`endif
    end else begin
      if (exp_pop) void'(q.pop_front());
      if (exp_ren) begin
        q.push_back('{now + 3 - 1, issue_pc, mem_word(issue_pc), 1'b0});
        issue_pc = issue_pc + 32'd4;
      end
    end
  endtask

  // One clock cycle: apply inputs just after a rising edge, check at the falling edge.
  task automatic tick(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    now++;
  endtask

  // Assert reset away from the clock edge, check reset outputs, release after two edges.
  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    #1;
    chk("rst_imem_rEn", {31'b0, imem_rEn}, 32'd0);
    chk("rst_imem_oEn", {31'b0, imem_oEn}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_misalign", {31'b0, out_misalign}, 32'd0);
    q.delete();
    issue_pc = RST_PC;
    halted   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int          base;
    logic        rv, rdy;
    logic [31:0] rpc;
    now     = 0;
    n_issue = 0;
    issue_pc = RST_PC;
    halted   = 1'b0;

    #2;
    do_reset();

    // Streaming from RESET_PC with decode always ready.
    for (int i = 0; i < 8; i++) tick(1'b0, 32'h0, 1'b1);

    // Backpressure from a clean redirect: exactly DEPTH reads, outputs held.
    tick(1'b1, 32'h0000_0400, 1'b0);
    base = n_issue;
    for (int i = 0; i < 10; i++) tick(1'b0, 32'h0, 1'b0);
    chk("bp_issues", n_issue - base, DEPTH);
    for (int i = 0; i < 4; i++) tick(1'b0, 32'h0, 1'b1);

    // Redirect with buffered entries and a read in flight.
    for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 1'b0);
    tick(1'b0, 32'h0, 1'b1);
    tick(1'b1, 32'h0000_2000, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b0, 32'h0, 1'b1);

    // PC wrap at the top of the address space.
    tick(1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b0, 32'h0, 1'b1);

    // Misaligned redirect, then an aligned one to resume.
    tick(1'b1, 32'h0000_2002, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b0, 32'h0, 1'b1);
    tick(1'b1, 32'h0000_3000, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b0, 32'h0, 1'b1);

    // Reset in the middle of a stream with out_valid high.
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    do_reset();
    for (int i = 0; i < 6; i++) tick(1'b0, 32'h0, 1'b1);

    // Random redirects (some misaligned, some near the wrap) and random backpressure.
    for (int i = 0; i < 3000; i++) begin
      rv  = ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) rpc[31:8] = 24'hFFFFFF;
      rdy = ($urandom_range(0, 9) < 7);
      tick(rv, rpc, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
